pm_sample_sequencer: RTL and testbench
======================================

// Module: pm_sample_sequencer
// PURPOSE
//  Front end for the particulate-matter (PM) occupancy counter.
//  - Synchronises and deglitches the raw PM sensor output (active-low = particle present).
//  - Generates the periodic one-cycle latch strobe that closes each counter sample window.
//  - Exposes period, control and status registers on the shared 8-bit membus.
//  - Raises an interrupt when a fresh sample is ready.
// PARAMETERS
//  MEMBUS_ADDRESS  8'h14    base address of the 4-byte register window (counter occupies 8'h10..13)
//  TICK_DIV        2000     clk_i cycles per period tick (2..65535)
//  PERIOD_RESET    16'd30000  period in ticks after reset
//  FILTER_LEN      4        consecutive equal synchronised samples required to change pm_filtered_o (2..16)
// PORTS
//  clk_i               in   1  system clock
//  rst_n_i             in   1  asynchronous active-low reset
//  membus_read_req_i   in   1  bus read strobe
//  membus_write_req_i  in   1  bus write strobe
//  membus_addr_i       in   7  bus address
//  membus_data_i       in   8  bus write data
//  membus_data_o       out  8  bus read data; 8'hZZ when this block is not addressed
//  pm_raw_i            in   1  asynchronous sensor output, low = particle present
//  pm_filtered_o       out  1  synchronised/filtered sensor level, to counter pm_input
//  pm_latch_o          out  1  one-cycle sample strobe, to counter pm_latch
//  irq_o               out  1  level interrupt: sample_ready & IRQ_EN
// BEHAVIOUR
//  Reset values: membus_data_o=Z, pm_filtered_o=1, pm_latch_o=0, irq_o=0,
//   period=PERIOD_RESET, ctrl=0, status=0, FSM=IDLE.
//  Registers at base+n:
//   0 PERIOD_LO (RW): written to a staging byte; read returns the live low byte.
//   1 PERIOD_HI (RW): a write commits {data, staging} atomically.
//   2 CTRL (RW): bit0 ENABLE, bit1 TRIGGER (write-1 pulse, reads 0), bit2 IRQ_EN.
//   3 STATUS (RO): bit0 SAMPLE_READY, bit1 OVERRUN. A read clears both bits.
//  A committed period of 0 is treated as 1.
//  Bus: reads are registered with 1-cycle latency. Unaddressed or idle cycles drive Z next cycle. Writes take effect on the strobe edge.
//  Prescaler: tick_cnt counts 0..TICK_DIV-1 while in RUN and emits a tick at the wrap.
//   per_cnt counts ticks 0..period-1.
//  FSM:
//   IDLE: ENABLE=0. Both counters are held at 0.
//    ENABLE=1 -> RUN. TRIGGER -> LATCH.
//   RUN: a tick with per_cnt==period-1 -> LATCH. TRIGGER -> LATCH. ENABLE=0 -> IDLE with no strobe.
//   LATCH: pm_latch_o=1 for exactly this cycle. Both counters clear.
//    Next state: RUN if ENABLE=1, else IDLE.
//  SAMPLE_READY is set in LATCH. If LATCH sets it while it is already set, OVERRUN is also set.
//   When a LATCH set and a STATUS-read clear occur in the same cycle, the set wins and the read returns the pre-set value.
//  Changing the period during RUN takes effect immediately. If per_cnt >= new period-1, the next tick latches.
//  TRIGGER while in LATCH is ignored.
//  Reset mid-window: everything returns to reset values, with no strobe.
//  The 2-FF input synchroniser is always present. pm_latch_o and pm_filtered_o are registered outputs.
// CONFIGURATION
//  PM_DEGLITCH_EN defined:
//   - pm_filtered_o changes only after FILTER_LEN consecutive identical synchronised samples.
//   - Latency from pm_raw_i is 2+FILTER_LEN cycles.
//   - Pulses shorter than FILTER_LEN cycles are removed.
//  PM_DEGLITCH_EN undefined:
//   - pm_filtered_o is the synchroniser output plus one register stage (3-cycle latency, no filtering).
// STRUCTURE
//  pm_pkg: register offsets (REG_PERIOD_LO..REG_STATUS), CTRL/STATUS bit indices, the FSM state enum (IDLE/RUN/LATCH), and a 16-bit period width constant.
//  Sub-module pm_input_filter: synchroniser plus optional deglitch, parameter FILTER_LEN.
//  Everything else (FSM, prescaler, registers, bus) is in this module.
// TESTING
//  Use TICK_DIV=4 and PERIOD_RESET=3 unless stated otherwise.
//  1. Write CTRL=0x01, then hold. Expect pm_latch_o pulses every 12 clk, each 1 cycle wide. Expect STATUS read = 0x01, then a re-read = 0x00.
//  2. Write LO=0x05, then wait 20 cycles (the period stays 3). Then write HI=0x00. Expect a period of 5 ticks (20 clk) from then on, and a readback of LO=0x05.
//  3. Let two latches pass without reading STATUS. Expect STATUS=0x03, and irq_o=1 only when CTRL bit2 is set.
//  4. In IDLE, write CTRL=0x02. Expect exactly one pm_latch_o pulse 1 cycle later, then none.
//     In RUN, clear ENABLE at per_cnt=2. Expect no pulse.
//  5. With PM_DEGLITCH_EN and FILTER_LEN=4: drive pm_raw_i low for 3 cycles -> pm_filtered_o stays 1.
//     Drive it low for 10 cycles -> pm_filtered_o goes low 6 cycles after the edge and stays low 10 cycles.
//     Without the macro, the 3-cycle pulse appears after 3 cycles.
//  6. Assert rst_n_i low mid-window, asynchronously. Expect all outputs to reach reset values immediately, and period readback = PERIOD_RESET.
//     Read an unmapped address (base+4). Expect membus_data_o=Z.

Source files
------------

// File: rtl/pm_sample_sequencer_pkg.sv
// Shared definitions for the PM sample sequencer: register offsets, CTRL/STATUS
// bit positions, sequencer states and the period width.
package pm_pkg;

  localparam int PERIOD_W = 16;

  localparam logic [1:0] REG_PERIOD_LO = 2'd0;
  localparam logic [1:0] REG_PERIOD_HI = 2'd1;
  localparam logic [1:0] REG_CTRL      = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_TRIGGER   = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_READY   = 0;
  localparam int STATUS_OVERRUN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LATCH = 2'd2
  } pm_state_e;

  // A programmed period of zero behaves as a one-tick window.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    if (p == {PERIOD_W{1'b0}}) begin
      eff_period = {{(PERIOD_W-1){1'b0}}, 1'b1};
    end else begin
      eff_period = p;
    end
  endfunction

endpackage

// File: rtl/pm_sample_sequencer_if.sv
// Shared 8-bit membus as seen by one register block; data_oe marks the cycles
// in which the block drives membus_data_o (otherwise it floats).
interface pm_sample_sequencer_if;
  logic       membus_read_req;
  logic       membus_write_req;
  logic [6:0] membus_addr;
  logic [7:0] membus_data_i;
  logic [7:0] membus_data_o;
  logic       membus_data_oe;

  modport master (
    output membus_read_req, membus_write_req, membus_addr, membus_data_i,
    input  membus_data_o, membus_data_oe
  );

  modport slave (
    input  membus_read_req, membus_write_req, membus_addr, membus_data_i,
    output membus_data_o, membus_data_oe
  );
endinterface

// File: rtl/pm_sample_sequencer_input_filter.sv
// Two-flop synchroniser for the raw PM sensor, followed by an optional
// FILTER_LEN-sample deglitcher enabled by the PM_DEGLITCH_EN macro.
module pm_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pm_raw_i,
  output logic pm_filtered_o
);

  logic sync1_q, sync2_q;
  logic filt_q, filt_d;

  // Sensor idles high (no particle), so the chain resets to 1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
    end else begin
      sync1_q <= pm_raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
    end
  end

`ifdef PM_DEGLITCH_EN
  localparam int                CNT_W    = $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive samples that disagree with the output; flips on the last.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = {CNT_W{1'b0}};
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    filt_d = sync2_q;
  end
`endif

  assign pm_filtered_o = filt_q;

endmodule

// File: rtl/pm_sample_sequencer.sv
// PM occupancy-counter front end: sample-window sequencer, membus register
// window and interrupt. Input deglitching is selected with PM_DEGLITCH_EN.
module pm_sample_sequencer
  import pm_pkg::*;
#(
  parameter logic [7:0]          MEMBUS_ADDRESS = 8'h14,
  parameter int                  TICK_DIV       = 2000,
  parameter logic [PERIOD_W-1:0] PERIOD_RESET   = 16'd30000,
  parameter int                  FILTER_LEN     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  pm_sample_sequencer_if.slave membus,
  input  logic                 pm_raw_i,
  output logic                 pm_filtered_o,
  output logic                 pm_latch_o,
  output logic                 irq_o
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  pm_state_e           state_q, state_d;
  logic [15:0]         tick_cnt_q, tick_cnt_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [7:0]          stage_q, stage_d;
  logic                enable_q, enable_d;
  logic                irq_en_q, irq_en_d;
  logic                ready_q, ready_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_oe_q, rd_oe_d;
  logic                latch_q, latch_d;
  logic                irq_q, irq_d;

  logic                hit_s, wr_s, rd_s, trigger_s, status_rd_s, tick_s, last_s;
  logic [1:0]          off_s;
  logic [PERIOD_W-1:0] period_eff_s;

  pm_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pm_raw_i      (pm_raw_i),
    .pm_filtered_o (pm_filtered_o)
  );

  assign hit_s        = (membus.membus_addr[6:2] == MEMBUS_ADDRESS[6:2]);
  assign off_s        = membus.membus_addr[1:0];
  assign wr_s         = membus.membus_write_req & hit_s;
  assign rd_s         = membus.membus_read_req & hit_s;
  assign trigger_s    = wr_s & (off_s == REG_CTRL) & membus.membus_data_i[CTRL_TRIGGER];
  assign status_rd_s  = rd_s & (off_s == REG_STATUS);
  assign period_eff_s = eff_period(period_q);
  assign tick_s       = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
  // Compare with >= so a period shortened below the current count closes on the next tick.
  assign last_s       = (per_cnt_q >= (period_eff_s - 16'd1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d = ST_LATCH;
        end else if (enable_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (trigger_s) begin
          state_d = ST_LATCH;
        end else if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (tick_s && last_s) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LATCH: begin
        state_d = enable_q ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_d = (state_d == ST_LATCH);
    irq_d   = ready_d & irq_en_d;
  end

  // The LATCH cycle counts as cycle 0 of the following window; IDLE holds both counters at 0.
  always_comb begin
    tick_cnt_d = 16'd0;
    per_cnt_d  = {PERIOD_W{1'b0}};
    if ((state_d == ST_RUN) && (state_q != ST_IDLE)) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? 16'd0 : (tick_cnt_q + 16'd1);
      per_cnt_d  = tick_s ? (per_cnt_q + 16'd1) : per_cnt_q;
    end else begin
      tick_cnt_d = 16'd0;
      per_cnt_d  = {PERIOD_W{1'b0}};
    end
  end

  always_comb begin
    period_d  = period_q;
    stage_d   = stage_q;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    rd_data_d = 8'h00;
    rd_oe_d   = 1'b0;
    if (wr_s) begin
      case (off_s)
        REG_PERIOD_LO: stage_d = membus.membus_data_i;
        REG_PERIOD_HI: period_d = {membus.membus_data_i, stage_q};
        REG_CTRL: begin
          enable_d = membus.membus_data_i[CTRL_ENABLE];
          irq_en_d = membus.membus_data_i[CTRL_IRQ_EN];
        end
        default: period_d = period_q;
      endcase
    end else begin
      period_d = period_q;
    end
    if (rd_s) begin
      rd_oe_d = 1'b1;
      case (off_s)
        REG_PERIOD_LO: rd_data_d = period_q[7:0];
        REG_PERIOD_HI: rd_data_d = period_q[15:8];
        REG_CTRL:      rd_data_d = {5'b00000, irq_en_q, 1'b0, enable_q};
        REG_STATUS:    rd_data_d = {6'b000000, overrun_q, ready_q};
        default:       rd_data_d = 8'h00;
      endcase
    end else begin
      rd_oe_d = 1'b0;
    end
    if (status_rd_s) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      ready_d = ready_q;
    end
    // A sample closing in the same cycle as a STATUS read is not lost.
    if (state_d == ST_LATCH) begin
      ready_d = 1'b1;
      if (ready_q) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_d;
      end
    end else begin
      ready_d = ready_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt_q <= 16'd0;
      per_cnt_q  <= {PERIOD_W{1'b0}};
      period_q   <= PERIOD_RESET;
      stage_q    <= 8'h00;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_oe_q    <= 1'b0;
      latch_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      per_cnt_q  <= per_cnt_d;
      period_q   <= period_d;
      stage_q    <= stage_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      rd_data_q  <= rd_data_d;
      rd_oe_q    <= rd_oe_d;
      latch_q    <= latch_d;
      irq_q      <= irq_d;
    end
  end

  assign membus.membus_data_o  = rd_oe_q ? rd_data_q : 8'hzz;
  assign membus.membus_data_oe = rd_oe_q;
  assign pm_latch_o            = latch_q;
  assign irq_o                 = irq_q;

endmodule

// File: tb/tb_pm_sample_sequencer.sv
// Scoreboard bench for pm_sample_sequencer (TICK_DIV=4, PERIOD_RESET=3).
// Honours PM_DEGLITCH_EN for the input-filter expectations.
module tb_pm_sample_sequencer;

  localparam logic [6:0] A_LO   = 7'h14;
  localparam logic [6:0] A_HI   = 7'h15;
  localparam logic [6:0] A_CTRL = 7'h16;
  localparam logic [6:0] A_ST   = 7'h17;
  localparam logic [6:0] A_BAD  = 7'h18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pm_raw = 1'b1;
  logic pm_filtered, pm_latch, irq;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int         lat_q[$];
  logic [7:0] rd_q[$];
  int         flt_cyc_q[$];
  logic       flt_val_q[$];
  logic       flt_prev = 1'b1;

  pm_sample_sequencer_if bus();

  pm_sample_sequencer #(
    .MEMBUS_ADDRESS (8'h14),
    .TICK_DIV       (4),
    .PERIOD_RESET   (16'd3),
    .FILTER_LEN     (4)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .membus        (bus),
    .pm_raw_i      (pm_raw),
    .pm_filtered_o (pm_filtered),
    .pm_latch_o    (pm_latch),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a strobe, read data or a level change.
  always @(negedge clk) begin
    if (pm_latch === 1'b1) begin
      if (lat_q.size() == 0) check("latch_unexpected", cyc, -1);
      else check("latch_cycle", cyc, lat_q.pop_front());
    end
    if (bus.membus_data_oe === 1'b1) begin
      if (rd_q.size() == 0) check("read_unexpected", int'(bus.membus_data_o), -1);
      else check("read_data", int'(bus.membus_data_o), int'(rd_q.pop_front()));
    end
    if (pm_filtered !== flt_prev) begin
      if (flt_cyc_q.size() == 0) begin
        check("filt_unexpected", cyc, -1);
      end else begin
        check("filt_cycle", cyc, flt_cyc_q.pop_front());
        check("filt_level", int'(pm_filtered), int'(flt_val_q.pop_front()));
      end
      flt_prev = pm_filtered;
    end
  end

  task automatic goto(input int e);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, output int e);
    bus.membus_write_req = 1'b1;
    bus.membus_addr      = a;
    bus.membus_data_i    = d;
    @(posedge clk);
    #1;
    bus.membus_write_req = 1'b0;
    e = cyc;
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus.membus_read_req = 1'b1;
    bus.membus_addr     = a;
    @(posedge clk);
    #1;
    bus.membus_read_req = 1'b0;
  endtask

  task automatic push_flt(input int c, input logic v);
    flt_cyc_q.push_back(c);
    flt_val_q.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int w, t, x, l, e0, e1, dummy;
    bus.membus_read_req  = 1'b0;
    bus.membus_write_req = 1'b0;
    bus.membus_addr      = 7'h00;
    bus.membus_data_i    = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_latch", int'(pm_latch), 0);
    check("rst_irq", int'(irq), 0);
    check("rst_filt", int'(pm_filtered), 1);
    check("rst_oe", int'(bus.membus_data_oe), 0);
    do_read(A_LO, 8'h03);
    do_read(A_HI, 8'h00);
    do_read(A_CTRL, 8'h00);
    do_read(A_ST, 8'h00);

    // Free-running period 3: strobes every 12 clocks, STATUS read-clear, overrun, irq gating.
    do_write(A_CTRL, 8'h01, w);
    lat_q.push_back(w + 13);
    lat_q.push_back(w + 25);
    lat_q.push_back(w + 37);
    goto(w + 16);
    do_read(A_ST, 8'h01);
    do_read(A_ST, 8'h00);
    goto(w + 30);
    check("irq_masked", int'(irq), 0);
    goto(w + 38);
    do_write(A_CTRL, 8'h05, dummy);
    check("irq_enabled", int'(irq), 1);
    goto(w + 40);
    do_read(A_ST, 8'h03);
    check("irq_cleared", int'(irq), 0);
    goto(w + 45);
    do_write(A_CTRL, 8'h00, dummy);   // disable with per_cnt==2: no strobe at w+49

    // Manual trigger from IDLE; a second trigger landing in LATCH is ignored.
    goto(w + 65);
    do_write(A_CTRL, 8'h02, t);
    lat_q.push_back(t);
    do_write(A_CTRL, 8'h02, dummy);
    goto(t + 6);
    do_read(A_ST, 8'h01);

    // Staged period write, atomic commit, then a period shortened mid-window.
    do_write(A_LO, 8'h05, x);
    goto(x + 20);
    do_read(A_LO, 8'h03);
    do_write(A_HI, 8'h00, dummy);
    do_read(A_LO, 8'h05);
    do_read(A_HI, 8'h00);
    do_write(A_CTRL, 8'h01, w);
    l = w + 41;
    lat_q.push_back(w + 21);
    lat_q.push_back(l);
    lat_q.push_back(l + 16);
    lat_q.push_back(l + 24);
    goto(l + 5);
    do_write(A_LO, 8'h02, dummy);
    goto(l + 13);
    do_write(A_HI, 8'h00, dummy);
    do_read(A_ST, 8'h03);
    goto(l + 16);
    do_read(A_ST, 8'h00);             // same cycle as a strobe: old value, set survives
    do_read(A_ST, 8'h01);
    goto(l + 26);
    do_write(A_CTRL, 8'h00, dummy);

    // Input path: 3-cycle and 10-cycle low pulses.
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    e0 = cyc;
`ifndef PM_DEGLITCH_EN
    push_flt(e0 + 3, 1'b0);
    push_flt(e0 + 6, 1'b1);
`endif
    pm_raw = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    pm_raw = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    e1 = cyc;
`ifdef PM_DEGLITCH_EN
    push_flt(e1 + 6, 1'b0);
    push_flt(e1 + 16, 1'b1);
`else
    push_flt(e1 + 3, 1'b0);
    push_flt(e1 + 13, 1'b1);
`endif
    pm_raw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    pm_raw = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a window (period is 2 here).
    do_write(A_CTRL, 8'h05, w);
    lat_q.push_back(w + 9);
    goto(w + 12);
    check("irq_before_reset", int'(irq), 1);
    goto(w + 15);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_latch", int'(pm_latch), 0);
    check("async_rst_irq", int'(irq), 0);
    check("async_rst_filt", int'(pm_filtered), 1);
    check("async_rst_oe", int'(bus.membus_data_oe), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(A_LO, 8'h03);
    do_read(A_HI, 8'h00);
    do_read(A_CTRL, 8'h00);
    do_read(A_ST, 8'h00);

    bus.membus_read_req = 1'b1;
    bus.membus_addr     = A_BAD;
    @(posedge clk);
    #1;
    bus.membus_read_req = 1'b0;
    check("unmapped_oe", int'(bus.membus_data_oe), 0);

    repeat (30) begin
      @(posedge clk);
      #1;
    end
    check("latch_leftover", lat_q.size(), 0);
    check("read_leftover", rd_q.size(), 0);
    check("filt_leftover", flt_cyc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
